// File: rtl/button_pkg.sv
// Shared types and helpers for the multi-channel button conditioner.
// Hold-FSM state encoding and a counter-width helper used by every channel.
package button_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PRESSED = 2'd1,
      ST_HELD    = 2'd2
   } hold_state_e;

   // Bits needed to hold values 0..value-1, never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned value);
      int unsigned w;
      w = $clog2(value);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: synchroniser, consecutive-sample integrator,
// registered edge pulses and a press/long-press/auto-repeat hold FSM.
module button_channel
   import button_pkg::*;
#(
   parameter int unsigned N           = 20,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LONG        = 1000,
   parameter int unsigned REPEAT      = 0
) (
   input  logic clk,
   input  logic sys_rst_n,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic long_o,
   output logic repeat_o
);

   localparam int unsigned CW = cnt_width(N + 1);
   localparam int unsigned HW = cnt_width(LONG + 1);
   localparam int unsigned RW = cnt_width(REPEAT + 1);

   localparam logic [CW-1:0] CNT_LAST  = CW'(N - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG - 1);
   localparam logic [RW-1:0] REP_LAST  = RW'((REPEAT > 0) ? (REPEAT - 1) : 0);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   hold_state_e   state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [RW-1:0] rep_q, rep_d;
   logic          long_q, long_d;
   logic          rpt_q, rpt_d;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         state_q <= ST_IDLE;
         hold_q  <= '0;
         rep_q   <= '0;
         long_q  <= 1'b0;
         rpt_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], din_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         state_q <= state_d;
         hold_q  <= hold_d;
         rep_q   <= rep_d;
         long_q  <= long_d;
         rpt_q   <= rpt_d;
      end
   end

   // Any sample agreeing with the current level restarts the count.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (s == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         level_d = ~level_q;
         rise_d  = ~level_q;
         fall_d  = level_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // The hold FSM keys off the same-cycle level toggle so its pulses line up
   // with rise/fall; a release overrides any long/repeat pulse due that cycle.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      rep_d   = rep_q;
      long_d  = 1'b0;
      rpt_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            hold_d = '0;
            rep_d  = '0;
            if (rise_d) begin
               state_d = ST_PRESSED;
            end
         end
         ST_PRESSED: begin
            if (hold_q == HOLD_LAST) begin
               long_d  = 1'b1;
               state_d = ST_HELD;
               rep_d   = '0;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         ST_HELD: begin
            if (REPEAT > 0) begin
               if (rep_q == REP_LAST) begin
                  rpt_d = 1'b1;
                  rep_d = '0;
               end else begin
                  rep_d = rep_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            hold_d  = '0;
            rep_d   = '0;
         end
      endcase
      if (fall_d) begin
         state_d = ST_IDLE;
         hold_d  = '0;
         rep_d   = '0;
         long_d  = 1'b0;
         rpt_d   = 1'b0;
      end
   end

   assign level_o  = level_q;
   assign rise_o   = rise_q;
   assign fall_o   = fall_q;
   assign long_o   = long_q;
   assign repeat_o = rpt_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: polarity correction ahead of the
// synchronisers, then one independent button_channel per input bit.
module button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned N           = 20,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned LONG        = 1000,
   parameter int unsigned REPEAT      = 0,
   parameter int unsigned ACTIVE_LOW  = 0
) (
   input  logic             clk,
   input  logic             sys_rst_n,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic [WIDTH-1:0] long_press,
   output logic [WIDTH-1:0] repeat_pulse
);

   logic [WIDTH-1:0] raw_pol;

   always_comb begin
      raw_pol = raw;
      if (ACTIVE_LOW != 0) begin
         raw_pol = ~raw;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      button_channel #(
         .N           (N),
         .SYNC_STAGES (SYNC_STAGES),
         .LONG        (LONG),
         .REPEAT      (REPEAT)
      ) u_ch (
         .clk       (clk),
         .sys_rst_n (sys_rst_n),
         .din_i     (raw_pol[g]),
         .level_o   (level[g]),
         .rise_o    (rise[g]),
         .fall_o    (fall[g]),
         .long_o    (long_press[g]),
         .repeat_o  (repeat_pulse[g])
      );
   end

endmodule
